// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// muldiv_pkg : shared encodings and state type for the Ex-stage mul/div unit
// Rev 1.0
// ============================================================================
package muldiv_pkg;

  localparam int ITER_DEFAULT = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] MT_NONE = 2'b00;
  localparam logic [1:0] MT_LO   = 2'b01;
  localparam logic [1:0] MT_HI   = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// muldiv_iter : one shift-add multiply or restoring-divide step per cycle
// Rev 1.0
// ============================================================================
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = ITER_DEFAULT
) (
  input  logic                 isDiv,
  input  logic [2*WIDTH-1:0]   acc,
  input  logic [WIDTH-1:0]     operand,
  output logic [2*WIDTH-1:0]   accNext,
  output logic                 qBit
);

  logic [WIDTH:0] w_addSum;
  logic [WIDTH:0] w_shRem;
  logic [WIDTH:0] w_trial;

  always_comb begin
    // Multiply: acc = {partial product, remaining multiplier bits}; shift right.
    w_addSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? operand : {WIDTH{1'b0}})};
    // Divide: acc = {remainder, remaining dividend bits}; shift left one bit.
    w_shRem  = acc[2*WIDTH-1:WIDTH-1];
    w_trial  = w_shRem - {1'b0, operand};
    qBit     = 1'b0;
    accNext  = {w_addSum, acc[WIDTH-1:1]};
    if (isDiv) begin
      qBit    = ~w_trial[WIDTH];
      // The quotient bit lands in accNext[0]; the caller merges qBit there.
      accNext = {(w_trial[WIDTH] ? w_shRem[WIDTH-1:0] : w_trial[WIDTH-1:0]),
                 acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule
`default_nettype wire

// File: rtl/ex_muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// ex_muldiv_ctrl : iterative MULT/DIV sequencer owning HI/LO for the Ex stage
// Rev 1.0
// ============================================================================
module ex_muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StartE,
  input  logic [1:0]      MulDivOpE,
  input  logic [1:0]      MtE,
  input  logic            FlushE,
  input  logic [ITER-1:0] SrcAE,
  input  logic [ITER-1:0] SrcBE,
  output logic            BusyE,
  output logic            DoneE,
  output logic [ITER-1:0] HI,
  output logic [ITER-1:0] LO,
  output logic            DivZeroE
);

  localparam int c_cntW = $clog2(ITER);

  state_t              r_state;
  logic [c_cntW-1:0]   r_count;
  logic [2*ITER-1:0]   r_acc;
  logic [ITER-1:0]     r_operand;
  logic [ITER-1:0]     r_hi;
  logic [ITER-1:0]     r_lo;
  logic                r_isDiv;
  logic                r_negQ;
  logic                r_negR;
  logic                r_divZero;
  logic                r_done;

  logic                w_divOp;
  logic                w_negA;
  logic                w_negB;
  logic [ITER-1:0]     w_absA;
  logic [ITER-1:0]     w_absB;
  logic [2*ITER-1:0]   w_accNext;
  logic                w_qBit;
  logic [2*ITER-1:0]   w_prod;
  logic [ITER-1:0]     w_quot;
  logic [ITER-1:0]     w_rem;
  logic [2*ITER-1:0]   w_result;

  always_comb begin
    w_divOp = isDivOp(MulDivOpE);
    w_negA  = isSignedOp(MulDivOpE) & SrcAE[ITER-1];
    w_negB  = isSignedOp(MulDivOpE) & SrcBE[ITER-1];
    w_absA  = w_negA ? -SrcAE : SrcAE;
    w_absB  = w_negB ? -SrcBE : SrcBE;
  end

  muldiv_iter #(.WIDTH(ITER)) u_iter (
    .isDiv   (r_isDiv),
    .acc     (r_acc),
    .operand (r_operand),
    .accNext (w_accNext),
    .qBit    (w_qBit)
  );

  // Sign fix-up; divide-by-zero keeps {dividend, all-ones} loaded at start.
  always_comb begin
    w_prod = r_negQ ? -r_acc : r_acc;
    w_quot = r_negQ ? -r_acc[ITER-1:0] : r_acc[ITER-1:0];
    w_rem  = r_negR ? -r_acc[2*ITER-1:ITER] : r_acc[2*ITER-1:ITER];
    if (r_divZero)    w_result = r_acc;
    else if (r_isDiv) w_result = {w_rem, w_quot};
    else              w_result = w_prod;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_acc     <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_isDiv   <= 1'b0;
      r_negQ    <= 1'b0;
      r_negR    <= 1'b0;
      r_divZero <= 1'b0;
      r_done    <= 1'b0;
    end else if (FlushE) begin
      r_state   <= ST_IDLE;
      r_divZero <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done    <= 1'b0;
          r_divZero <= 1'b0;
          if (StartE) begin
            r_isDiv <= w_divOp;
            r_negQ  <= w_negA ^ w_negB;
            r_negR  <= w_negA;
            if (w_divOp && (SrcBE == '0)) begin
              r_acc     <= {SrcAE, {ITER{1'b1}}};
              r_divZero <= 1'b1;
              r_done    <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_acc     <= {{ITER{1'b0}}, (w_divOp ? w_absA : w_absB)};
              r_operand <= w_divOp ? w_absB : w_absA;
              r_count   <= c_cntW'(ITER - 1);
              r_state   <= ST_CALC;
            end
          end else if (MtE == MT_LO) begin
            r_lo <= SrcAE;
          end else if (MtE == MT_HI) begin
            r_hi <= SrcAE;
          end
        end
        ST_CALC: begin
          r_acc <= w_accNext | {{(2*ITER-1){1'b0}}, w_qBit};
          if (r_count == '0) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end else begin
            r_count <= r_count - c_cntW'(1);
          end
        end
        ST_DONE: begin
          {r_hi, r_lo} <= w_result;
          r_state      <= ST_IDLE;
          r_done       <= 1'b0;
          r_divZero    <= 1'b0;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A flush arriving in DONE suppresses the completion pulse for that cycle.
  assign BusyE    = ((r_state == ST_IDLE) & StartE & ~FlushE) | (r_state == ST_CALC);
  assign DoneE    = r_done & ~FlushE;
  assign DivZeroE = r_divZero & ~FlushE;
  assign HI       = r_hi;
  assign LO       = r_lo;

endmodule
`default_nettype wire
